vga_scan_gen: RTL and testbench

- Raster timing generator that produces the pixel coordinates consumed by the title/sprite pixel generators, which decide whether a pixel is lit from signed 11-bit x/y.
- Produces hsync/vsync, a visible-area flag, a pixel-rate enable and a frame-start pulse.
- Default timing is 640x480@60 Hz from a 50 MHz system clock.
- Sits at the top of the display path, feeding the pixel generators and the RGB mux.

---
 rtl/vga_pkg.sv | 36 +++
 rtl/vga_pix_div.sv | 43 ++++
 rtl/vga_scan_gen.sv | 143 ++++++++++++++
 tb/tb_vga_scan_gen.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared screen-space package for the display path.
// Holds the 640x480@60 Hz timing constants, the derived line/frame totals,
// the signed coordinate type used by the scan generator and the pixel
// generators, and small helpers for timing arithmetic.
package vga_pkg;

  localparam int COORD_W = 11;

  typedef logic signed [COORD_W-1:0] coord_t;

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;

  // Total period of a line or frame from its four timing segments.
  function automatic int scan_total(int visible, int front, int sync, int back);
    return visible + front + sync + back;
  endfunction

  localparam int VGA_H_TOTAL = scan_total(VGA_H_VISIBLE, VGA_H_FRONT, VGA_H_SYNC, VGA_H_BACK);
  localparam int VGA_V_TOTAL = scan_total(VGA_V_VISIBLE, VGA_V_FRONT, VGA_V_SYNC, VGA_V_BACK);

  // True when lo <= c < hi; the coordinate is sign-extended so the compare
  // stays signed and width-matched.
  function automatic logic in_span(coord_t c, int lo, int hi);
    int ci;
    ci = int'(c);
    return (ci >= lo) && (ci < hi);
  endfunction

endpackage

// File: rtl/vga_pix_div.sv
// Pixel-rate clock-enable divider.
// Counts 0..CLK_DIV-1 and raises pix_en for exactly the clock in which the
// count sits at CLK_DIV-1. With CLK_DIV=1 pix_en is high every clock after
// reset.
// Ports:
//   clk    - system clock
//   rst_n  - asynchronous active-low reset
//   pix_en - one-clock pixel-advance strobe
module vga_pix_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic pix_en
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_p0;
  logic [DIV_W-1:0] div_nxt;
  logic             pix_en_p0;

  always_comb begin
    div_nxt = (div_p0 == DIV_LAST) ? '0 : div_p0 + 1'b1;
  end

  // ---- stage p0: divider count and its registered decode ----
  // pix_en is registered from the next count so it is low during reset yet
  // still lines up with the cycle in which the count equals CLK_DIV-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_p0    <= '0;
      pix_en_p0 <= 1'b0;
    end else begin
      div_p0    <= div_nxt;
      pix_en_p0 <= (div_nxt == DIV_LAST);
    end
  end

  assign pix_en = pix_en_p0;

endmodule

// File: rtl/vga_scan_gen.sv
// Raster scan generator for the display path.
// Produces signed pixel coordinates x/y, hsync/vsync, the visible-area flag,
// the pixel-rate enable and a frame-start pulse. x, y, hsync, vsync,
// video_on and frame_start are registered together one clock after the
// counters move, so they always describe the same pixel.
// Optional feature macro: VGA_FRAME_CNT_EN -- when defined, frame_cnt counts
// completed frames (wrapping 255 -> 0, advancing with frame_start); when
// undefined, frame_cnt is tied to zero and no counter is built.
// Ports:
//   clk         - system clock
//   rst_n       - asynchronous active-low reset
//   pix_en      - one-clock strobe every CLK_DIV clocks (pixel advance)
//   x, y        - current column / line, signed, always non-negative
//   hsync       - horizontal sync, active level HS_POL
//   vsync       - vertical sync, active level VS_POL
//   video_on    - high inside the visible area
//   frame_start - one-clock pulse when the scan wraps to (0,0)
//   frame_cnt   - completed-frame counter (see macro above)
module vga_scan_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = VGA_H_VISIBLE,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_VISIBLE = VGA_V_VISIBLE,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BACK    = VGA_V_BACK,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic                      pix_en,
  output logic signed [COORD_W-1:0] x,
  output logic signed [COORD_W-1:0] y,
  output logic                      hsync,
  output logic                      vsync,
  output logic                      video_on,
  output logic                      frame_start,
  output logic [7:0]                frame_cnt
);

  localparam int H_TOTAL  = scan_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL  = scan_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;

  vga_pix_div #(
    .CLK_DIV(CLK_DIV)
  ) u_pix_div (
    .clk   (clk),
    .rst_n (rst_n),
    .pix_en(pix_en)
  );

  coord_t h_cnt_p0;
  coord_t v_cnt_p0;
  logic   h_last;
  logic   v_last;

  assign h_last = (int'(h_cnt_p0) == H_TOTAL - 1);
  assign v_last = (int'(v_cnt_p0) == V_TOTAL - 1);

  // ---- stage p0: raster counters, advanced on pix_en ----
  // Line and frame wrap happen in the same pix_en cycle, so (H_TOTAL-1,
  // V_TOTAL-1) is followed directly by (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_p0 <= '0;
      v_cnt_p0 <= '0;
    end else if (pix_en) begin
      if (h_last) begin
        h_cnt_p0 <= '0;
        v_cnt_p0 <= v_last ? '0 : v_cnt_p0 + coord_t'(1);
      end else begin
        h_cnt_p0 <= h_cnt_p0 + coord_t'(1);
      end
    end
  end

  coord_t x_p1;
  coord_t y_p1;
  logic   hsync_p1;
  logic   vsync_p1;
  logic   video_on_p1;
  logic   frame_start_p1;
  logic   frame_wrap;

  // The counters sit at (0,0) while the registered coordinate still shows the
  // previous pixel only in the first clock after a frame wrap. Right after
  // reset both are already (0,0), which keeps the first frame from pulsing.
  assign frame_wrap = (h_cnt_p0 == '0) && (v_cnt_p0 == '0) &&
                      !((x_p1 == '0) && (y_p1 == '0));

  // ---- stage p1: registered coordinate, sync and flag outputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_p1           <= '0;
      y_p1           <= '0;
      hsync_p1       <= ~HS_POL;
      vsync_p1       <= ~VS_POL;
      video_on_p1    <= 1'b0;
      frame_start_p1 <= 1'b0;
    end else begin
      x_p1           <= h_cnt_p0;
      y_p1           <= v_cnt_p0;
      hsync_p1       <= in_span(h_cnt_p0, HS_START, HS_END) ? HS_POL : ~HS_POL;
      vsync_p1       <= in_span(v_cnt_p0, VS_START, VS_END) ? VS_POL : ~VS_POL;
      video_on_p1    <= in_span(h_cnt_p0, 0, H_VISIBLE) && in_span(v_cnt_p0, 0, V_VISIBLE);
      frame_start_p1 <= frame_wrap;
    end
  end

  assign x           = x_p1;
  assign y           = y_p1;
  assign hsync       = hsync_p1;
  assign vsync       = vsync_p1;
  assign video_on    = video_on_p1;
  assign frame_start = frame_start_p1;

`ifdef VGA_FRAME_CNT_EN
  logic [7:0] frame_cnt_p1;

  // Advances in the same clock that frame_start is shown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_p1 <= '0;
    end else if (frame_wrap) begin
      frame_cnt_p1 <= frame_cnt_p1 + 8'd1;
    end
  end

  assign frame_cnt = frame_cnt_p1;
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_scan_gen.sv
// Testbench for vga_scan_gen using a reduced raster so that several hundred
// frames fit in a short run: 8 pixels per line (4 visible, 1 front, 2 sync,
// 1 back) and 7 lines per frame (3 visible, 1 front, 2 sync, 1 back), two
// system clocks per pixel. Expected pixels are queued when reset is released;
// a monitor pops one entry on every pix_en cycle and also checks that the
// outputs hold between pixel advances.
module tb_vga_scan_gen;

  localparam int CD  = 2;
  localparam int HV  = 4, HF = 1, HSW = 2, HB = 1;
  localparam int VV  = 3, VF = 1, VSW = 2, VB = 1;
  localparam int HT  = 8;
  localparam int VT  = 7;
  localparam int FP  = HT * VT;   // 56 pixels per frame
`ifdef VGA_FRAME_CNT_EN
  localparam int FC_BEFORE_WRAP = 255;
`else
  localparam int FC_BEFORE_WRAP = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pix_en, hsync, vsync, video_on, frame_start;
  logic signed [10:0] x, y;
  logic [7:0] frame_cnt;

  vga_scan_gen #(
    .CLK_DIV(CD),
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .x(x), .y(y),
    .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int hs;
    int vs;
    int von;
    int fs;
    int fc;
  } exp_t;

  typedef struct {
    int   k;
    exp_t e;
  } dir_t;

  exp_t sb[$];
  dir_t dirs[$];

  int vectors = 0;
  int errors  = 0;

  logic mon_on      = 1'b0;
  logic have_last   = 1'b0;
  int   pix_idx     = 0;
  int   cyc         = 0;
  int   last_fs_cyc = -1;
  exp_t last_e;

  task automatic chk(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (pixel %0d, t=%0t)", name, act, req, pix_idx, $time);
    end
  endtask

  // Expected outputs for the k-th pixel shown after reset release.
  function automatic exp_t model(input int k);
    exp_t e;
    int p;
    p     = k % FP;
    e.x   = p % HT;
    e.y   = p / HT;
    e.hs  = (e.x == 5 || e.x == 6) ? 0 : 1;
    e.vs  = (e.y == 4 || e.y == 5) ? 0 : 1;
    e.von = (e.x < 4 && e.y < 3) ? 1 : 0;
    e.fs  = (k > 0 && p == 0) ? 1 : 0;
`ifdef VGA_FRAME_CNT_EN
    e.fc  = (k / FP) % 256;
`else
    e.fc  = 0;
`endif
    return e;
  endfunction

  task automatic add_dir(input int k, input int ex, input int ey, input int hs,
                         input int vs, input int von, input int fs, input int fc);
    dir_t d;
    d.k = k; d.e.x = ex; d.e.y = ey; d.e.hs = hs; d.e.vs = vs;
    d.e.von = von; d.e.fs = fs; d.e.fc = fc;
    dirs.push_back(d);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_x"}, int'(x), 0);
    chk({tag, "_y"}, int'(y), 0);
    chk({tag, "_hsync"}, int'(hsync), 1);
    chk({tag, "_vsync"}, int'(vsync), 1);
    chk({tag, "_video_on"}, int'(video_on), 0);
    chk({tag, "_pix_en"}, int'(pix_en), 0);
    chk({tag, "_frame_start"}, int'(frame_start), 0);
    chk({tag, "_frame_cnt"}, int'(frame_cnt), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_on) begin
      cyc++;
      if (pix_en) begin
        if (sb.size() == 0) begin
          chk("scoreboard_underflow", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("x", int'(x), e.x);
          chk("y", int'(y), e.y);
          chk("hsync", int'(hsync), e.hs);
          chk("vsync", int'(vsync), e.vs);
          chk("video_on", int'(video_on), e.von);
          chk("frame_start", int'(frame_start), e.fs);
          chk("frame_cnt", int'(frame_cnt), e.fc);
          foreach (dirs[i]) begin
            if (dirs[i].k == pix_idx) begin
              chk("dir_x", int'(x), dirs[i].e.x);
              chk("dir_y", int'(y), dirs[i].e.y);
              chk("dir_hsync", int'(hsync), dirs[i].e.hs);
              chk("dir_vsync", int'(vsync), dirs[i].e.vs);
              chk("dir_video_on", int'(video_on), dirs[i].e.von);
              chk("dir_frame_start", int'(frame_start), dirs[i].e.fs);
              if (dirs[i].e.fc >= 0) chk("dir_frame_cnt", int'(frame_cnt), dirs[i].e.fc);
            end
          end
          if (frame_start) begin
            if (last_fs_cyc >= 0) chk("frame_period_clks", cyc - last_fs_cyc, FP * CD);
            last_fs_cyc = cyc;
          end
          last_e    = e;
          have_last = 1'b1;
        end
        pix_idx++;
      end else if (have_last) begin
        chk("hold_x", int'(x), last_e.x);
        chk("hold_y", int'(y), last_e.y);
        chk("hold_hsync", int'(hsync), last_e.hs);
        chk("hold_vsync", int'(vsync), last_e.vs);
        chk("hold_video_on", int'(video_on), last_e.von);
        chk("frame_start_one_clk", int'(frame_start), 0);
        chk("hold_frame_cnt", int'(frame_cnt), last_e.fc);
      end
    end
  end

  task automatic start_run(input int npix);
    sb.delete();
    for (int k = 0; k < npix; k++) sb.push_back(model(k));
    pix_idx     = 0;
    cyc         = 0;
    last_fs_cyc = -1;
    have_last   = 1'b0;
  endtask

  task automatic drain(input int budget_clks);
    int budget;
    budget = budget_clks;
    while (sb.size() != 0 && budget > 0) begin
      @(negedge clk);
      #1;
      budget--;
    end
    mon_on = 1'b0;
    chk("scoreboard_left_over", sb.size(), 0);
  endtask

  initial begin
    int lat;
    int n1;
    int n2;
    int budget;

    // Hand-computed pixels of the reduced raster.
    add_dir(0,  0, 0, 1, 1, 1, 0, -1);
    add_dir(4,  4, 0, 1, 1, 0, 0, -1);   // video_on drops at x = visible width
    add_dir(5,  5, 0, 0, 1, 0, 0, -1);   // hsync starts
    add_dir(7,  7, 0, 1, 1, 0, 0, -1);   // hsync over, last column
    add_dir(8,  0, 1, 1, 1, 1, 0, -1);   // line wrap
    add_dir(35, 3, 4, 1, 0, 0, 0, -1);   // first vsync line
    add_dir(47, 7, 5, 1, 0, 0, 0, -1);   // last vsync pixel
    add_dir(55, 7, 6, 1, 1, 0, 0, 0);    // last pixel of frame
    add_dir(56, 0, 0, 1, 1, 1, 1, -1);   // frame wrap straight to origin
    add_dir(256 * FP - 1, 7, 6, 1, 1, 0, 0, FC_BEFORE_WRAP);
    add_dir(256 * FP,     0, 0, 1, 1, 1, 1, 0);

    // Reset held for five clocks.
    rst_n = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk_reset_values("in_reset");
    end

    // Long run: 256 frames plus a few pixels.
    n1 = 256 * FP + 8;
    start_run(n1);
    #1;
    rst_n  = 1'b1;
    mon_on = 1'b1;
    lat = 1;
    while (!pix_en && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("first_pix_en_clks", lat, CD);
    drain(n1 * CD + 50);

    // Reset in the middle of a frame.
    budget = 400;
    while (int'(y) != 3 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("reached_line_3", int'(y), 3);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_values("async_reset");
    repeat (3) @(negedge clk);
    chk_reset_values("held_reset");

    // Resume from the origin with a full first frame.
    n2 = 2 * FP + 2;
    start_run(n2);
    #1;
    rst_n  = 1'b1;
    mon_on = 1'b1;
    drain(n2 * CD + 50);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
